// File: rtl/mat_mul_seq_if.sv
// Stream and datapath signals of the mat_mul sequencer.
// The slave modport is the sequencer's view. The master modport is the system side.
interface mat_mul_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PROD_W = 32
);
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mm_data;
    logic              mm_load;
    logic              mm_done;
    logic [3:0]        mm_address;
    logic [PROD_W-1:0] mm_product;
    logic [PROD_W-1:0] out_data;
    logic [3:0]        out_addr;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              job_done;
    logic              err;

    modport slave (
        input  start, in_data, in_valid, mm_done, mm_product, out_ready,
        output in_ready, mm_data, mm_load, mm_address, out_data, out_addr, out_valid,
        output busy, job_done, err
    );

    modport master (
        output start, in_data, in_valid, mm_done, mm_product, out_ready,
        input  in_ready, mm_data, mm_load, mm_address, out_data, out_addr, out_valid,
        input  busy, job_done, err
    );
endinterface

// File: rtl/mat_mul_seq.sv
// Sequencer for the 4x4 mat_mul datapath. It feeds 32 operand words with fixed load pulses,
// waits for done, then streams out the 16 products.
module mat_mul_seq #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned PROD_W       = 32,
    parameter int unsigned N_WORDS      = 32,
    parameter int unsigned N_OUT        = 16,
    parameter int unsigned LOAD_HIGH    = 3,
    parameter int unsigned LOAD_GAP     = 2,
    parameter int unsigned ADDR_SETTLE  = 2,
    parameter int unsigned DONE_TIMEOUT = 4096
) (
    input logic          clk,
    input logic          rst_n,
    mat_mul_seq_if.slave bus
);

    localparam int unsigned TW = ($clog2(DONE_TIMEOUT + 1) > 4) ? $clog2(DONE_TIMEOUT + 1) : 4;

    typedef enum logic [3:0] {
        StIdle, StWaitWord, StSetup, StLoadHi, StLoadLo, StWaitDone, StAddr, StOut, StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [5:0]        word_cnt_q, word_cnt_d;
    logic [3:0]        elem_q, elem_d;
    logic [DATA_W-1:0] mm_data_q, mm_data_d;
    logic [PROD_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_addr_q, out_addr_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            word_cnt_q <= '0;
            elem_q     <= '0;
            mm_data_q  <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
            elem_q     <= elem_d;
            mm_data_q  <= mm_data_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            err_q      <= err_d;
        end
    end

    // cnt_q is zeroed on entry to every timed state, so each compare is against (cycles - 1).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_cnt_d = word_cnt_q;
        elem_d     = elem_q;
        mm_data_d  = mm_data_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    err_d      = 1'b0;
                    word_cnt_d = '0;
                    elem_d     = '0;
                    state_d    = StWaitWord;
                end
            end
            StWaitWord: begin
                if (bus.in_valid) begin
                    mm_data_d = bus.in_data;
                    if (word_cnt_q != 6'(N_WORDS)) word_cnt_d = word_cnt_q + 6'd1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StLoadHi;
            end
            StLoadHi: begin
                if (cnt_q == TW'(LOAD_HIGH - 1)) begin
                    cnt_d   = '0;
                    state_d = StLoadLo;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StLoadLo: begin
                if (cnt_q == TW'(LOAD_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = (word_cnt_q == 6'(N_WORDS)) ? StWaitDone : StWaitWord;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StWaitDone: begin
                if (bus.mm_done) begin
                    cnt_d   = '0;
                    elem_d  = '0;
                    state_d = StAddr;
                end else if (cnt_q == TW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StAddr: begin
                if (cnt_q == TW'(ADDR_SETTLE - 1)) begin
                    out_data_d = bus.mm_product;
                    out_addr_d = elem_q;
                    state_d    = StOut;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    if (elem_q == 4'(N_OUT - 1)) begin
                        state_d = StFinish;
                    end else begin
                        elem_d  = elem_q + 4'd1;
                        cnt_d   = '0;
                        state_d = StAddr;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign bus.in_ready   = (state_q == StWaitWord);
    assign bus.mm_data    = mm_data_q;
    assign bus.mm_load    = (state_q == StLoadHi);
    assign bus.mm_address = elem_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_valid  = (state_q == StOut);
    assign bus.busy       = (state_q != StIdle);
    assign bus.job_done   = (state_q == StFinish);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_mat_mul_seq.sv
// Scoreboard bench for mat_mul_seq. It drives a behavioural mat_mul model and checks products
// against hand-computed expectations, load waveform, stalls, timeout and reset.
module tb_mat_mul_seq;
    localparam int unsigned TO = 64;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  a;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mat_mul_seq_if #(.DATA_W(16), .PROD_W(32)) bus ();

    mat_mul_seq #(.DONE_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic        start_main, ill_start, in_valid, out_ready, suppress_done, force_done;
    logic [15:0] in_data;
    assign bus.start     = start_main | ill_start;
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;

    logic [15:0] ja [32] = '{2, 8, 12, 1, 5, 15, 33, 21, 100, 0, 9, 25, 0, 2, 10, 34,
                             4, 16, 45, 21, 6, 3, 50, 71, 22, 0, 1, 30, 5, 15, 27, 40};
    logic [15:0] jb [32] = '{4, 16, 45, 21, 6, 3, 50, 71, 22, 0, 1, 30, 5, 15, 27, 40,
                             1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [31:0] pa [16] = '{325, 71, 529, 1010, 941, 440, 1575, 3000,
                             723, 1975, 5184, 3370, 402, 516, 1028, 1802};

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Behavioural mat_mul: captures mm_data on each load rising edge, raises done 8 cycles later.
    logic [15:0] mw [32];
    int          mcnt, mdelay;
    logic        mload_prev, mdone;
    logic [31:0] mm_prod;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 0; mdelay <= 0; mload_prev <= 1'b0; mdone <= 1'b0;
        end else begin
            mload_prev <= bus.mm_load;
            if (bus.mm_load && !mload_prev) begin
                if (mcnt >= 32) begin
                    mw[0] <= bus.mm_data; mcnt <= 1; mdone <= 1'b0;
                end else begin
                    mw[mcnt[4:0]] <= bus.mm_data; mcnt <= mcnt + 1;
                    if (mcnt == 31) mdelay <= 8;
                end
            end else if (mdelay > 0) begin
                mdelay <= mdelay - 1;
                if (mdelay == 1) mdone <= 1'b1;
            end
        end
    end
    always_comb begin
        mm_prod = '0;
        for (int k = 0; k < 4; k++)
            mm_prod = mm_prod + 32'(mw[{bus.mm_address[3:2], 2'(k)}])
                    * 32'(mw[16 + k * 4 + int'(bus.mm_address[1:0])]);
    end
    assign bus.mm_product = mm_prod;
    assign bus.mm_done    = (mdone & ~suppress_done) | force_done;

    // Output monitor: every out_valid cycle must show the scoreboard head.
    int   outs_seen = 0, jd_count = 0, jd_run = 0;
    logic jd_expect = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (jd_expect) begin
                check("job_done_after_last", bus.job_done, 1);
                jd_expect = 1'b0;
            end
            if (bus.job_done) begin
                if (jd_run == 0) jd_count++;
                jd_run++;
            end else begin
                if (jd_run != 0) check("job_done_width", jd_run, 1);
                jd_run = 0;
            end
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got addr %0d data %0d, want no output",
                             bus.out_addr, bus.out_data);
                end else begin
                    check("out_data", bus.out_data, sbq[0].d);
                    check("out_addr", bus.out_addr, sbq[0].a);
                    check("mm_address_in_out", bus.mm_address, sbq[0].a);
                    if (bus.out_ready) begin
                        if (sbq[0].a == 4'd15) jd_expect = 1'b1;
                        void'(sbq.pop_front());
                        outs_seen++;
                    end
                end
            end
        end else begin
            jd_expect = 1'b0; jd_run = 0;
        end
    end

    // Load waveform monitor, enabled for the back-to-back job only.
    logic        lw_en = 1'b0, prev_load = 1'b0;
    logic [15:0] prev_mmd = '0;
    int          hi_run = 0, lo_run = 0, pulses = 0;
    initial forever begin
        @(negedge clk);
        if (lw_en) begin
            if (pulses >= 32 && bus.mm_load && !prev_load) begin
                checks++; errors++;
                $display("FAIL extra_load_pulse: got pulse %0d want 32 pulses", pulses + 1);
            end else if (bus.mm_load) begin
                if (!prev_load) begin
                    if (pulses > 0) check("load_gap", lo_run, 4);
                    check("data_before_rise", prev_mmd, ja[pulses]);
                    hi_run = 0;
                end
                hi_run++;
                check("data_during_load", bus.mm_data, ja[pulses]);
            end else begin
                if (prev_load && pulses < 32) begin
                    check("load_high", hi_run, 3);
                    check("data_after_fall", bus.mm_data, ja[pulses]);
                    pulses++;
                    lo_run = 0;
                end
                lo_run++;
            end
        end
        prev_load = bus.mm_load;
        prev_mmd  = bus.mm_data;
    end

    // Backpressure: hold out_ready low 5 cycles when element 7 is presented.
    logic stall_en = 1'b0;
    int   stall_seen = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_en && bus.out_valid && bus.out_addr == 4'd7) begin
                out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                out_ready = 1'b1;
                stall_seen++;
            end
        end
    end

    // Illegal events: start in LOAD_HI, done during loading, start in OUT.
    logic ill_en = 1'b0;
    int   ill_stage = 0;
    initial begin
        ill_start = 1'b0; force_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ill_en) begin
                if (ill_stage == 0 && bus.mm_load) begin
                    ill_start = 1'b1; @(negedge clk); ill_start = 1'b0; ill_stage = 1;
                end else if (ill_stage == 1 && mcnt >= 5) begin
                    force_done = 1'b1; repeat (10) @(negedge clk); force_done = 1'b0;
                    ill_stage = 2;
                end else if (ill_stage == 2 && bus.out_valid) begin
                    ill_start = 1'b1; @(negedge clk); ill_start = 1'b0; ill_stage = 3;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want $finish before 200000 ns");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(posedge clk); #1;
        start_main = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        start_main = 1'b0;
    endtask

    task automatic send_job(input int which, input bit gaps, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            bit ok = 1'b0;
            int gap = gaps ? int'($urandom_range(0, 4)) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            in_data  = (which == 0) ? ja[w] : jb[w];
            in_valid = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    @(posedge clk); #1;
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL in_handshake_timeout: got no in_ready for word %0d, want one", w);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input int which);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.d = (which == 0) ? pa[i] : 32'(jb[i]);
            e.a = 4'(i);
            sbq.push_back(e);
        end
    endtask

    task automatic finish_job(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.busy) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        check({tag, "_reached_idle"}, 32'(ok), 1);
        check({tag, "_busy_end"}, bus.busy, 0);
        check({tag, "_outputs"}, outs_seen, 16);
        check({tag, "_queue_empty"}, sbq.size(), 0);
        check({tag, "_job_done_count"}, jd_count, 1);
        check({tag, "_err"}, bus.err, 0);
        outs_seen = 0; jd_count = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_mm_data"}, bus.mm_data, 0);
        check({tag, "_mm_load"}, bus.mm_load, 0);
        check({tag, "_mm_address"}, bus.mm_address, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_addr"}, bus.out_addr, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_job_done"}, bus.job_done, 0);
        check({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        bit found;
        start_main = 1'b0; in_valid = 1'b0; in_data = '0;
        suppress_done = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        rst_n = 1'b1;

        // Job 1: back-to-back words; start and in_valid together in IDLE must not accept.
        lw_en = 1'b1;
        push_exp(0);
        in_data = ja[0]; in_valid = 1'b1;
        do_start();
        send_job(0, 1'b0, 32);
        finish_job("job1");
        lw_en = 1'b0;
        check("load_pulses", pulses, 32);

        // Job 2: random input gaps and a 5-cycle output stall on element 7.
        stall_en = 1'b1;
        push_exp(0);
        do_start();
        send_job(0, 1'b1, 32);
        finish_job("job2");
        stall_en = 1'b0;
        check("stall_happened", stall_seen, 1);

        // Job 3: stray start pulses and an early mm_done.
        ill_en = 1'b1;
        push_exp(0);
        do_start();
        send_job(0, 1'b0, 32);
        finish_job("job3");
        ill_en = 1'b0;
        check("illegal_events_injected", ill_stage, 3);

        // Timeout: mm_done never seen.
        suppress_done = 1'b1;
        do_start();
        send_job(0, 1'b0, 32);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mm_load) begin found = 1'b1; break; end
        end
        for (int i = 0; i < 10 && bus.mm_load; i++) @(negedge clk);
        check("to_last_pulse_seen", 32'(found), 1);
        check("to_last_pulse_fell", bus.mm_load, 0);
        repeat (65) @(negedge clk);
        check("to_err_before", bus.err, 0);
        check("to_busy_before", bus.busy, 1);
        @(negedge clk);
        check("to_err_set", bus.err, 1);
        check("to_busy_clear", bus.busy, 0);
        check("to_no_out_valid", bus.out_valid, 0);
        repeat (5) @(negedge clk);
        check("to_err_sticky", bus.err, 1);
        suppress_done = 1'b0;
        do_start();
        check("to_err_cleared_by_start", bus.err, 0);
        check("to_busy_after_start", bus.busy, 1);

        // Reset after word 10, then a fresh job.
        send_job(1, 1'b0, 10);
        check("rst_mm_data_before", bus.mm_data, 32'(jb[9]));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1);
        do_start();
        send_job(1, 1'b0, 32);
        finish_job("job_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
